// File: rtl/rz_uart_pkg.sv
// Shared types and defaults for the rz_uart transmit queue and its storage.
package rz_uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } sched_state_e;

    // One RZ frame is start + data + stop, plus one guard cycle.
    function automatic int default_frame_cycles(input int data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/rz_uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; occupancy count only with RZ_UART_TX_QUEUE_LEVEL_EN.
module rz_uart_fifo
    import rz_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en;
    logic                  rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Guard here as well so a misbehaving caller cannot corrupt the pointers.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
    localparam int LW = $clog2(DEPTH + 1);

    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: rtl/rz_uart_tx_queue.sv
// Buffers words and issues them to rz_uart as tx_valid pulses at least one frame apart.
// Optional level output under RZ_UART_TX_QUEUE_LEVEL_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no frame in flight; counter 0; issue as soon as FIFO non-empty
// ST_GAP  | frame in flight; counter counts down to 0 before next issue
module rz_uart_tx_queue
    import rz_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int FRAME_CYCLES = default_frame_cycles(DATA_WIDTH)
) (
    input  logic                  tx_clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int              CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_CYCLES - 1);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_push = s_valid & ~fifo_full;

    rz_uart_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (tx_clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (s_data),
        .pop        (fifo_pop),
        .pop_data   (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = head_data;
                    cnt_d      = RELOAD;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!fifo_empty) begin
                    // Reload and stay in GAP so a steady queue issues exactly every frame.
                    fifo_pop   = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = head_data;
                    cnt_d      = RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign s_ready  = ~fifo_full;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = ~fifo_empty | (state_q == ST_GAP);

endmodule

// File: tb/tb_rz_uart_tx_queue.sv
// Bench for rz_uart_tx_queue: queue-based pacing model checked every cycle plus directed literal checks.
module tb_rz_uart_tx_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int FC    = 11;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          tx_clk = 1'b0;
    logic          reset  = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          busy;
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
    logic [LW-1:0] level;
`endif

    rz_uart_tx_queue #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .FRAME_CYCLES (FC)
    ) dut (
        .tx_clk   (tx_clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .busy     (busy)
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: words waiting in order, and edges elapsed since the last pulse.
    // A word goes out when the queue holds one and a full frame has elapsed.
    logic [DW-1:0] m_q[$];
    int            m_since = FC;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    bit            m_on    = 1'b0;
    bit            m_iss;
    bit            m_acc;

    logic          smp_tick  = 1'b0;
    logic          smp_reset = 1'b0;
    logic          smp_valid = 1'b0;
    logic [DW-1:0] smp_data  = '0;
    int            cyc       = 0;

    logic [DW-1:0] emitted[$];
    int            etimes[$];
    int            max_level = 0;

    always @(posedge tx_clk) begin
        smp_tick  <= 1'b1;
        smp_reset <= reset;
        smp_valid <= s_valid;
        smp_data  <= s_data;
        cyc       <= cyc + 1;
    end

    task automatic model_step();
        if (smp_reset) begin
            m_q.delete();
            m_since = FC;
            m_valid = 1'b0;
            m_data  = '0;
            m_on    = 1'b1;
        end else begin
            m_iss = (m_q.size() > 0) && (m_since >= FC - 1);
            m_acc = smp_valid && (m_q.size() < DEPTH);
            if (m_iss) begin
                m_data  = m_q.pop_front();
                m_since = 0;
            end else if (m_since < FC) begin
                m_since++;
            end
            m_valid = m_iss;
            if (m_acc) m_q.push_back(smp_data);
        end
    endtask

    always @(negedge tx_clk) begin
        if (smp_tick) model_step();
        if (m_on) begin
            chk("cyc_tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
            chk("cyc_tx_data", {24'd0, tx_data}, {24'd0, m_data});
            chk("cyc_s_ready", {31'd0, s_ready}, {31'd0, (m_q.size() < DEPTH)});
            chk("cyc_busy", {31'd0, busy}, {31'd0, ((m_q.size() > 0) || (m_since < FC))});
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
            chk("cyc_level", 32'(level), 32'(m_q.size()));
            if (int'(level) > max_level) max_level = int'(level);
`endif
            if (tx_valid === 1'b1) begin
                emitted.push_back(tx_data);
                etimes.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step(1);
            n++;
        end
        chk("drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Holds s_valid high and advances to the next word only on accepted edges.
    bit saw_full;
    task automatic send_words(input logic [DW-1:0] src[$]);
        int idx;
        int guard;
        bit acc;
        idx   = 0;
        guard = 0;
        s_valid = 1'b1;
        while (idx < src.size() && guard < 2000) begin
            s_data = src[idx];
            acc = s_ready;
            if (!acc) saw_full = 1'b1;
            step(1);
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        chk("send_timeout", 32'(idx), 32'(src.size()));
    endtask

    logic [DW-1:0] src[$];
    int            n;

    initial begin
        step(2);
        reset = 1'b0;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        chk("rst_level", 32'(level), 32'd0);
`endif

        // Single word: pulse in the cycle after edge N+1, busy high FC cycles from the pulse.
        emitted.delete();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step(1);
        s_valid = 1'b0;
        chk("t1_no_early_pulse", {31'd0, tx_valid}, 32'd0);
        chk("t1_busy_rise", {31'd0, busy}, 32'd1);
        step(1);
        chk("t1_pulse", {31'd0, tx_valid}, 32'd1);
        chk("t1_data", {24'd0, tx_data}, 32'hA5);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step(1);
        end
        chk("t1_busy_len", 32'(n), 32'd11);
        chk("t1_count", 32'(emitted.size()), 32'd1);

        // Three back-to-back pushes: pulses spaced by exactly 11 cycles.
        step(3);
        emitted.delete();
        etimes.delete();
        src = '{8'h01, 8'h02, 8'h03};
        send_words(src);
        wait_drain();
        chk("t2_count", 32'(emitted.size()), 32'd3);
        if (emitted.size() == 3 && etimes.size() == 3) begin
            chk("t2_w0", {24'd0, emitted[0]}, 32'h01);
            chk("t2_w1", {24'd0, emitted[1]}, 32'h02);
            chk("t2_w2", {24'd0, emitted[2]}, 32'h03);
            chk("t2_gap01", 32'(etimes[1] - etimes[0]), 32'd11);
            chk("t2_gap12", 32'(etimes[2] - etimes[1]), 32'd11);
        end

        // 20 incrementing words against a 16-deep queue.
        step(3);
        emitted.delete();
        src.delete();
        for (int i = 0; i < 20; i++) src.push_back(DW'(i));
        saw_full  = 1'b0;
        max_level = 0;
        send_words(src);
        chk("t3_saw_full", {31'd0, saw_full}, 32'd1);
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        chk("t3_peak_level", 32'(max_level), 32'd16);
`endif
        wait_drain();
        chk("t3_count", 32'(emitted.size()), 32'd20);
        for (int i = 0; i < 20 && i < emitted.size(); i++)
            chk("t3_order", {24'd0, emitted[i]}, 32'(i));
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        chk("t3_drained_level", 32'(level), 32'd0);
`endif

        // Reset mid-gap discards the queue; the next word is first out.
        step(2);
        src = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        send_words(src);
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t4_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t4_s_ready", {31'd0, s_ready}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        chk("t4_level", 32'(level), 32'd0);
`endif
        emitted.delete();
        step(FC);
        chk("t4_quiet", 32'(emitted.size()), 32'd0);
        src = '{8'h3C};
        send_words(src);
        wait_drain();
        chk("t4_count", 32'(emitted.size()), 32'd1);
        if (emitted.size() > 0) chk("t4_first", {24'd0, emitted[0]}, 32'h3C);

        // Burst of 10 random words comes out intact and in order.
        step(2);
        emitted.delete();
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(DW'($urandom_range(0, 255)));
        send_words(src);
        wait_drain();
        chk("t5_count", 32'(emitted.size()), 32'd10);
        for (int i = 0; i < 10 && i < emitted.size(); i++)
            chk("t5_order", {24'd0, emitted[i]}, {24'd0, src[i]});

        // Interleaved pushes and pops; occupancy checked every cycle by the model.
        step(2);
        emitted.delete();
        for (int i = 0; i < 12; i++) begin
            src = '{DW'(8'h80 + i)};
            send_words(src);
            step(3 + (i % 5));
        end
        wait_drain();
        chk("t6_count", 32'(emitted.size()), 32'd12);
        for (int i = 0; i < 12 && i < emitted.size(); i++)
            chk("t6_order", {24'd0, emitted[i]}, 32'(8'h80 + i));
`ifdef RZ_UART_TX_QUEUE_LEVEL_EN
        chk("t6_final_level", 32'(level), 32'd0);
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
